pid_core_v2: RTL
================

PID_CORE_V2 -- requirements
Module: pid_core_v2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, setpoint/feedback/output width.
REQ-002 SHALL have parameter GAIN_W, default 8, unsigned gain width.
REQ-003 SHALL have parameter FRAC_W, default 2, gain fractional bits; sum is shifted right by FRAC_W before clamping.
REQ-004 SHALL have parameter ACC_W, default 20, signed width of integral accumulator and term sum.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port sample_valid, input, 1, new setpoint/feedback pair offered.
REQ-008 SHALL have port sample_ready, output, 1, core idle and able to accept a sample.
REQ-009 SHALL have ports setpoint and feedback, input, DATA_W each, unsigned operands.
REQ-010 SHALL have ports kp, ki and kd, input, GAIN_W each, unsigned staged gains.
REQ-011 SHALL have port gain_load, input, 1, capture kp/ki/kd into the shadow gain registers.
REQ-012 SHALL have port integ_clr, input, 1, request to clear integral and prev_error.
REQ-013 SHALL have port out_valid, output, 1, one-cycle pulse when control_signal updates.
REQ-014 SHALL have port control_signal, output, DATA_W, unsigned clamped output, held between updates.
REQ-015 SHALL have ports sat_hi and sat_lo, output, 1 each, last output clamped high or low.

Function
REQ-016 FSM SHALL be IDLE -> ERR -> PTERM -> ITERM -> DTERM -> SAT -> IDLE, advancing one state per cycle with no stalls.
REQ-017 A sample SHALL be accepted on the clk edge where sample_valid and sample_ready are both 1; sample_ready SHALL equal (state==IDLE).
REQ-018 Latency SHALL be fixed: sample accepted at edge N gives out_valid=1 for exactly the cycle after edge N+5; the next accept is possible at edge N+6.
REQ-019 ERR SHALL compute error = setpoint - feedback as signed DATA_W+1 bits, and delta = error - prev_error as signed DATA_W+2 bits.
REQ-020 PTERM/ITERM/DTERM SHALL time-share one signed multiplier; gains SHALL be zero-extended; all products SHALL be sign-extended to ACC_W.
REQ-021 Integral update SHALL be integral += ki*error, saturating at [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-022 Anti-windup: the integral update SHALL be skipped when (sat_hi and error>0) or (sat_lo and error<0).
REQ-023 SAT SHALL form sum = P+I+D (saturating, ACC_W), arithmetic-shift right by FRAC_W, then clamp to [0, 2^DATA_W-1].
REQ-024 SAT SHALL set sat_hi/sat_lo from that clamp, and update prev_error <= error.
REQ-025 gain_load SHALL be sampled every cycle into a pending flag plus staging copy (the last load wins); shadow gains SHALL update only in IDLE, so gains never change mid-computation.
REQ-026 integ_clr SHALL be latched pending; it SHALL be applied in IDLE before any accept in the same cycle, clearing integral, prev_error, sat_hi and sat_lo.
REQ-027 sample_valid outside IDLE SHALL be ignored, with no queuing.

Reset
REQ-028 rst_n low SHALL force state IDLE, control_signal 0, out_valid 0, sat_hi/sat_lo 0, integral 0, prev_error 0, pending flags 0 and shadow gains 0, regardless of clk.
REQ-029 Reset mid-computation SHALL discard the sample, with no out_valid pulse; sample_ready SHALL be 1 on the first cycle after release.

Structure
REQ-030 The FSM state enum and default parameter constants SHALL live in shared package pid_pkg.
REQ-031 The shared multiplier SHALL be sub-module pid_mul (signed GAIN_W+1 x DATA_W+2, product sign-extended to ACC_W).

Verification
REQ-032 Defaults, kp=8, ki=4, kd=4 loaded; setpoint=100, feedback=90 -> out_valid 6 cycles after accept, control_signal=40, sat flags 0.
REQ-033 Repeat the same sample -> control_signal=40 (P=80, I=80, D=0).
REQ-034 setpoint=0, feedback=200 -> control_signal=0, sat_lo=1; a second identical sample leaves integral unchanged (anti-windup).
REQ-035 gain_load with kp=0 asserted during PTERM -> current output uses old kp; the next sample uses kp=0.
REQ-036 rst_n low during ITERM -> no out_valid pulse, control_signal=0, sample_ready=1 after release.
REQ-037 integ_clr pulse while busy -> the next sample sees integral=0 and prev_error=0 (setpoint=100, feedback=90 gives 40 again).

Source files
------------

// File: rtl/pid_pkg.sv
// pid_pkg: shared FSM state type and default parameter constants for the PID core
package pid_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_GAIN_W = 8;
  localparam int DEF_FRAC_W = 2;
  localparam int DEF_ACC_W  = 20;
  typedef enum logic [2:0] {IDLE, ERR, PTERM, ITERM, DTERM, SAT} state_t;
endpackage

// File: rtl/pid_mul.sv
// pid_mul: zero-extended unsigned gain times signed operand, product sign-extended to ACC_W (gain, op -> prod)
module pid_mul #(
  parameter int GAIN_W = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic        [GAIN_W-1:0] gain,
  input  logic signed [DATA_W+1:0] op,
  output logic signed [ACC_W-1:0]  prod
);
  localparam int PW = GAIN_W + DATA_W + 3;
  logic signed [PW-1:0] ge, oe, p;
  assign ge = {{(PW-GAIN_W){1'b0}}, gain};
  assign oe = {{(PW-DATA_W-2){op[DATA_W+1]}}, op};
  assign p = ge * oe;
  assign prod = {{(ACC_W-PW){p[PW-1]}}, p};
endmodule

// File: rtl/pid_core_v2.sv
// pid_core_v2: six-state time-shared PID controller (clk, rst_n, sample_valid/ready, setpoint, feedback, kp/ki/kd, gain_load, integ_clr -> out_valid, control_signal, sat_hi, sat_lo)
module pid_core_v2 import pid_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int GAIN_W = DEF_GAIN_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] setpoint,
  input  logic [DATA_W-1:0] feedback,
  input  logic [GAIN_W-1:0] kp,
  input  logic [GAIN_W-1:0] ki,
  input  logic [GAIN_W-1:0] kd,
  input  logic              gain_load,
  input  logic              integ_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] control_signal,
  output logic              sat_hi,
  output logic              sat_lo
);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  state_t state;
  logic [DATA_W-1:0] sp_r, fb_r, cs_c;
  logic signed [DATA_W:0] err, prev_err, err_c;
  logic signed [DATA_W+1:0] delta, mul_op;
  logic [GAIN_W-1:0] kp_s, ki_s, kd_s, kp_st, ki_st, kd_st, mul_gain;
  logic gain_pend, clr_pend, skip, sat_hi_c, sat_lo_c;
  logic signed [ACC_W-1:0] integral, p_term, d_term, prod, isat, ssat, shifted;
  logic signed [ACC_W:0] isum;
  logic signed [ACC_W+1:0] tsum;
  assign sample_ready = state == IDLE;
  pid_mul #(.GAIN_W(GAIN_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_mul (
    .gain(mul_gain),
    .op  (mul_op),
    .prod(prod)
  );
  always_comb begin
    err_c = $signed({1'b0, sp_r}) - $signed({1'b0, fb_r});
    mul_gain = state == PTERM ? kp_s : state == ITERM ? ki_s : kd_s;
    mul_op = state == DTERM ? delta : {err[DATA_W], err};
    skip = (sat_hi && !err[DATA_W] && |err) || (sat_lo && err[DATA_W]);
    isum = {integral[ACC_W-1], integral} + {prod[ACC_W-1], prod};
    isat = isum[ACC_W] == isum[ACC_W-1] ? isum[ACC_W-1:0] : isum[ACC_W] ? ACC_MIN : ACC_MAX;
    tsum = {{2{p_term[ACC_W-1]}}, p_term} + {{2{integral[ACC_W-1]}}, integral} + {{2{d_term[ACC_W-1]}}, d_term};
    ssat = (&tsum[ACC_W+1:ACC_W-1] || ~|tsum[ACC_W+1:ACC_W-1]) ? tsum[ACC_W-1:0] : tsum[ACC_W+1] ? ACC_MIN : ACC_MAX;
    shifted = ssat >>> FRAC_W;
    sat_hi_c = shifted > OUT_MAX;
    sat_lo_c = shifted[ACC_W-1];
    cs_c = sat_hi_c ? '1 : sat_lo_c ? '0 : shifted[DATA_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sp_r <= '0;
      fb_r <= '0;
      err <= '0;
      prev_err <= '0;
      delta <= '0;
      integral <= '0;
      p_term <= '0;
      d_term <= '0;
      kp_s <= '0;
      ki_s <= '0;
      kd_s <= '0;
      kp_st <= '0;
      ki_st <= '0;
      kd_st <= '0;
      gain_pend <= 1'b0;
      clr_pend <= 1'b0;
      control_signal <= '0;
      out_valid <= 1'b0;
      sat_hi <= 1'b0;
      sat_lo <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (gain_load) begin
        kp_st <= kp;
        ki_st <= ki;
        kd_st <= kd;
      end
      gain_pend <= gain_load | (gain_pend & state != IDLE);
      clr_pend <= (integ_clr | clr_pend) & (state != IDLE);
      case (state)
        IDLE: begin
          if (gain_pend) begin
            kp_s <= kp_st;
            ki_s <= ki_st;
            kd_s <= kd_st;
          end
          if (integ_clr | clr_pend) begin
            integral <= '0;
            prev_err <= '0;
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
          end
          if (sample_valid) begin
            sp_r <= setpoint;
            fb_r <= feedback;
            state <= ERR;
          end
        end
        ERR: begin
          err <= err_c;
          delta <= {err_c[DATA_W], err_c} - {prev_err[DATA_W], prev_err};
          state <= PTERM;
        end
        PTERM: begin
          p_term <= prod;
          state <= ITERM;
        end
        ITERM: begin
          if (!skip) integral <= isat;
          state <= DTERM;
        end
        DTERM: begin
          d_term <= prod;
          state <= SAT;
        end
        SAT: begin
          control_signal <= cs_c;
          sat_hi <= sat_hi_c;
          sat_lo <= sat_lo_c;
          prev_err <= err;
          out_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
